boot_loader: RTL and testbench



---
 rtl/boot_loader_if.sv | 22 ++
 rtl/boot_loader.sv | 122 ++++++++++++
 tb/tb_boot_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The loader takes the slave view: it sinks the byte stream and sources memory writes.
interface boot_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/boot_loader.sv
// Framed program loader: count byte, 4*N little-endian payload bytes, checksum byte.
// Writes words into instruction memory from address 0 and releases the core on a good image.
module boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  boot_loader_if.slave  bus,
  input  logic          reload,
  output logic          cpu_rst_n,
  output logic          done,
  output logic          err
);

  localparam int IDX_W     = ADDR_W - 2;
  localparam int MAX_WORDS = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] last_idx;
  logic [1:0]       lane;
  logic [7:0]       sum;
  logic [23:0]      lanes;
  logic             accept;
  logic             in_ready_d, done_d, err_d, cpu_rst_n_d;

  function automatic logic count_bad(input logic [7:0] n);
    return (n == 8'd0) || (int'(n) > MAX_WORDS);
  endfunction

  function automatic logic checksum_ok(input logic [7:0] s, input logic [7:0] c);
    logic [7:0] total;
    total = s + c;
    return total == 8'd0;
  endfunction

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bus.in_ready <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      cpu_rst_n    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus.in_ready <= in_ready_d;
      done         <= done_d;
      err          <= err_d;
      cpu_rst_n    <= cpu_rst_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = count_bad(bus.in_data) ? S_ERR : S_LOAD;
      S_LOAD:  if (accept && lane == 2'd3 && word_idx == last_idx) state_d = S_CHECK;
      S_CHECK: if (accept) state_d = checksum_ok(sum, bus.in_data) ? S_DONE : S_ERR;
      S_DONE,
      S_ERR:   if (reload) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they leave the chip straight from flops.
  always_comb begin
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_CHECK);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    cpu_rst_n_d = (state_d == S_DONE);
  end

  // Word assembly: lanes 0..2 are buffered, the 4th byte completes the word and fires the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx     <= '0;
      last_idx     <= '0;
      lane         <= 2'd0;
      sum          <= 8'd0;
      lanes        <= 24'd0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= 32'd0;
    end else begin
      bus.im_we <= 1'b0;
      if (accept) begin
        unique case (state_q)
          S_IDLE: begin
            last_idx <= IDX_W'(bus.in_data - 8'd1);
            word_idx <= '0;
            lane     <= 2'd0;
            sum      <= 8'd0;
          end
          S_LOAD: begin
            sum  <= sum + bus.in_data;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              bus.im_we    <= 1'b1;
              bus.im_addr  <= {word_idx, 2'b00};
              bus.im_wdata <= {bus.in_data, lanes};
              word_idx     <= word_idx + IDX_W'(1);
            end else begin
              lanes[lane*8 +: 8] <= bus.in_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized frame-level bench for boot_loader with a byte/word reference model and write scoreboard.
module tb_boot_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic reload;
  logic cpu_rst_n, done, err;

  boot_loader_if #(.ADDR_W(8)) bus ();

  boot_loader #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .reload    (reload),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] words[$];
  logic [7:0]  frame[$];
  wr_t         exp_q[$];
  int          wr_cyc[$];
  logic [7:0]  last_addr;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write strobe must match the next expected (address, word) pair.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.im_we === 1'b1) begin
      wr_t e;
      wr_cyc.push_back(cyc);
      last_addr = bus.im_addr;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", bus.im_addr, bus.im_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.im_addr !== e.addr || bus.im_wdata !== e.data) begin
          n_errors++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   bus.im_addr, bus.im_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame builder from the format rules: count, LE payload, checksum making the payload sum 0 mod 256.
  task automatic make_frame(input bit corrupt);
    int         s;
    logic [7:0] b;
    logic [7:0] c;
    frame.delete();
    frame.push_back(8'(words.size()));
    s = 0;
    for (int k = 0; k < words.size(); k++) begin
      for (int i = 0; i < 4; i++) begin
        b = 8'((words[k] >> (8 * i)) & 32'hFF);
        s += int'(b);
        frame.push_back(b);
      end
      exp_q.push_back('{addr: 8'(4 * k), data: words[k]});
    end
    c = 8'((256 - (s % 256)) % 256);
    if (corrupt) c = c + 8'd1;
    frame.push_back(c);
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < frame.size(); i++) begin
      if (max_gap > 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(max_gap, 1)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = frame[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(negedge clk);
    n_checks += 7;
    if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    if (bus.im_we !== 1'b0) begin n_errors++; $display("FAIL reset_im_we: got %b, expected 0", bus.im_we); end
    if (bus.im_addr !== 8'h00) begin n_errors++; $display("FAIL reset_im_addr: got %h, expected 00", bus.im_addr); end
    if (bus.im_wdata !== 32'h0) begin n_errors++; $display("FAIL reset_im_wdata: got %h, expected 0", bus.im_wdata); end
    if (cpu_rst_n !== 1'b0) begin n_errors++; $display("FAIL reset_cpu_rst_n: got %b, expected 0", cpu_rst_n); end
    if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b, expected 0", err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    words = '{32'h11223344, 32'hAABBCCDD};
    wr_cyc.delete();
    make_frame(1'b0);
    send_frame(0);
    n_checks += 6;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL good_writes_missing: got %0d pending, expected 0", exp_q.size()); exp_q.delete(); end
    if (wr_cyc.size() != 2 || wr_cyc[1] - wr_cyc[0] != 4) begin n_errors++; $display("FAIL good_write_spacing: got %0d writes, expected 2 writes 4 cycles apart", wr_cyc.size()); end
    if (done !== 1'b1) begin n_errors++; $display("FAIL good_done: got %b, expected 1", done); end
    if (cpu_rst_n !== 1'b1) begin n_errors++; $display("FAIL good_cpu_rst_n: got %b, expected 1", cpu_rst_n); end
    if (err !== 1'b0) begin n_errors++; $display("FAIL good_err: got %b, expected 0", err); end
    if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL good_in_ready: got %b, expected 0", bus.in_ready); end
  endtask

  task automatic test_bad_checksum();
    do_reload();
    words = '{32'h11223344, 32'hAABBCCDD};
    make_frame(1'b1);
    send_frame(0);
    n_checks += 5;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL badsum_writes_missing: got %0d pending, expected 0", exp_q.size()); exp_q.delete(); end
    if (err !== 1'b1) begin n_errors++; $display("FAIL badsum_err: got %b, expected 1", err); end
    if (done !== 1'b0) begin n_errors++; $display("FAIL badsum_done: got %b, expected 0", done); end
    if (cpu_rst_n !== 1'b0) begin n_errors++; $display("FAIL badsum_cpu_rst_n: got %b, expected 0", cpu_rst_n); end
    if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL badsum_in_ready: got %b, expected 0", bus.in_ready); end
  endtask

  task automatic test_bad_count();
    logic [7:0] counts[2];
    counts[0] = 8'h00;
    counts[1] = 8'h41;
    wr_cyc.delete();
    for (int i = 0; i < 2; i++) begin
      do_reload();
      frame.delete();
      frame.push_back(counts[i]);
      send_frame(0);
      n_checks += 3;
      if (err !== 1'b1) begin n_errors++; $display("FAIL badcount_err n=%h: got %b, expected 1", counts[i], err); end
      if (cpu_rst_n !== 1'b0) begin n_errors++; $display("FAIL badcount_cpu_rst_n n=%h: got %b, expected 0", counts[i], cpu_rst_n); end
      if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL badcount_in_ready n=%h: got %b, expected 0", counts[i], bus.in_ready); end
    end
    n_checks++;
    if (wr_cyc.size() != 0) begin n_errors++; $display("FAIL badcount_writes: got %0d, expected 0", wr_cyc.size()); end
  endtask

  task automatic test_max_frame();
    do_reload();
    words.delete();
    for (int k = 0; k < 64; k++) words.push_back($urandom());
    wr_cyc.delete();
    make_frame(1'b0);
    send_frame(5);
    n_checks += 5;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL max_writes_missing: got %0d pending, expected 0", exp_q.size()); exp_q.delete(); end
    if (wr_cyc.size() != 64) begin n_errors++; $display("FAIL max_write_count: got %0d, expected 64", wr_cyc.size()); end
    if (last_addr !== 8'hFC) begin n_errors++; $display("FAIL max_last_addr: got %h, expected fc", last_addr); end
    if (done !== 1'b1) begin n_errors++; $display("FAIL max_done: got %b, expected 1", done); end
    if (cpu_rst_n !== 1'b1) begin n_errors++; $display("FAIL max_cpu_rst_n: got %b, expected 1", cpu_rst_n); end
  endtask

  task automatic test_reset_midframe();
    do_reload();
    words = '{$urandom(), $urandom()};
    wr_cyc.delete();
    make_frame(1'b0);
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = frame[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_in_ready: got %b, expected 1", bus.in_ready); end
    if (bus.im_addr !== 8'h00 || bus.im_wdata !== 32'h0) begin n_errors++; $display("FAIL midrst_bus: got addr=%h data=%h, expected 00/0", bus.im_addr, bus.im_wdata); end
    if (cpu_rst_n !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL midrst_status: got cpu_rst_n=%b done=%b err=%b, expected 000", cpu_rst_n, done, err); end
    if (bus.im_we !== 1'b0) begin n_errors++; $display("FAIL midrst_im_we: got %b, expected 0", bus.im_we); end
    if (wr_cyc.size() != 1) begin n_errors++; $display("FAIL midrst_writes: got %0d, expected 1", wr_cyc.size()); end
    if (exp_q.size() != 1) begin n_errors++; $display("FAIL midrst_pending: got %0d, expected 1", exp_q.size()); end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    words = '{$urandom()};
    make_frame(1'b0);
    send_frame(2);
    n_checks += 2;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL midrst_fresh_writes: got %0d pending, expected 0", exp_q.size()); exp_q.delete(); end
    if (done !== 1'b1) begin n_errors++; $display("FAIL midrst_fresh_done: got %b, expected 1", done); end
  endtask

  task automatic test_reload_with_valid();
    reload       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    @(negedge clk);
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    n_checks += 3;
    if (cpu_rst_n !== 1'b0) begin n_errors++; $display("FAIL reload_cpu_rst_n: got %b, expected 0", cpu_rst_n); end
    if (done !== 1'b0) begin n_errors++; $display("FAIL reload_done: got %b, expected 0", done); end
    if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reload_in_ready: got %b, expected 1", bus.in_ready); end
    words = '{$urandom()};
    make_frame(1'b0);
    send_frame(0);
    n_checks += 2;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL reload_writes: got %0d pending, expected 0", exp_q.size()); exp_q.delete(); end
    if (done !== 1'b1) begin n_errors++; $display("FAIL reload_new_done: got %b, expected 1", done); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      do_reload();
      words.delete();
      for (int k = 0; k < int'($urandom_range(8, 2)); k++) words.push_back($urandom());
      wr_cyc.delete();
      make_frame(1'b0);
      send_frame(0);
      n_checks += 3;
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL b2b_writes: got %0d pending, expected 0", exp_q.size()); exp_q.delete(); end
      for (int i = 1; i < wr_cyc.size(); i++) begin
        n_checks++;
        if (wr_cyc[i] - wr_cyc[i-1] != 4) begin n_errors++; $display("FAIL b2b_spacing: got %0d cycles, expected 4", wr_cyc[i] - wr_cyc[i-1]); end
      end
      if (wr_cyc.size() != words.size()) begin n_errors++; $display("FAIL b2b_count: got %0d, expected %0d", wr_cyc.size(), words.size()); end
      if (done !== 1'b1) begin n_errors++; $display("FAIL b2b_done: got %b, expected 1", done); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_count();
    test_max_frame();
    test_reset_midframe();
    test_reload_with_valid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
